cpu_clk_ctrl: RTL and testbench
===============================

# cpu_clk_ctrl

Run/step/halt sequencer for the divided CPU clock of the single-cycle CPU board build. Produces a programmable-ratio square clock plus a one-cycle clock-enable pulse per CPU cycle from the board clock. Accepts runtime divisor changes through a valid/ready handshake and applies them only at period boundaries, so the output never glitches. Sits between the board clock/buttons and the CPU core; the core advances only on O_CE.

## Interface
- DEF_DIV, 32'd20: reset full period of O_CLK in I_CLK cycles.
- MIN_DIV, 32'd2: smallest accepted divisor; smaller requests are clamped to it.

- I_CLK  input  1  board clock; the only clock.
- RST  input  1  asynchronous, active-high reset.
- I_MODE  input  2  00 HALT, 01 RUN, 10 STEP, 11 treated as HALT.
- I_STEP  input  1  step request, synchronous to I_CLK and debounced upstream; rising edge = one step.
- I_DIV  input  32  requested full period in I_CLK cycles.
- I_DIV_VALID  input  1  I_DIV offered.
- O_DIV_READY  output  1  can accept a new divisor.
- O_CLK  output  1  divided CPU clock, registered.
- O_CE  output  1  one-I_CLK-cycle pulse, high in the same cycle O_CLK goes 0->1.
- O_HALTED  output  1  high while in IDLE.
- O_CYCLES  output  32  count of O_CE pulses since reset.

## Operation
- Registers: state {IDLE, RUN, STEP}, cnt[31:0], div_cur, div_pend, pend flag, step_prev, cycle counter.
- H = div_cur >> 1; O_CLK period = 2*H (odd divisors truncate).
- Counting, active in RUN/STEP: if cnt == H, toggle O_CLK and set cnt <= 1; else cnt <= cnt + 1.
- Boundary = the edge where O_CLK toggles 1->0; in IDLE, every edge is a boundary.
- IDLE: O_CLK held 0, cnt held at 0.
  - I_MODE == RUN -> RUN, cnt <= 1.
  - I_MODE == STEP and I_STEP && !step_prev -> STEP, cnt <= 1.
- RUN, at a boundary:
  - I_MODE != RUN -> IDLE.
  - Otherwise continue.
  - Mode changes mid-period never truncate the high phase.
- STEP, at its boundary: always -> IDLE, giving exactly one period. Step edges seen during STEP are dropped, not queued.
- Divisor handshake:
  - Transfer when I_DIV_VALID && O_DIV_READY: div_pend <= max(I_DIV, MIN_DIV), pend <= 1, O_DIV_READY <= 0.
  - At the next boundary with pend: div_cur <= div_pend, pend <= 0; O_DIV_READY is 1 from the following cycle.
  - The new H governs the period that starts at that boundary.
  - In IDLE, apply occurs on the edge after acceptance.
- Boundary coinciding with a mode change: the divisor applies and the state transition occurs on the same edge.
- O_CYCLES increments with each O_CE and wraps 2^32-1 -> 0.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE, cnt 0, O_CLK 0, O_CE 0, O_HALTED 1, O_CYCLES 0.
  - O_DIV_READY 1, pend 0, div_cur DEF_DIV, step_prev 0.
- Reset mid-period: O_CLK forced 0 at once; in-flight divisor request discarded.
- Start latency: mode/step sampled at edge k -> O_CLK and O_CE rise after edge k+H, O_CLK falls after edge k+2H.
- STEP returns to IDLE (O_HALTED 1) after edge k+2H.
- O_HALTED is registered from state and deasserts after edge k.
- Handshake latency: acceptance to apply is at most one full period (2*H old cycles). O_DIV_READY stays low for that whole interval.
- I_DIV_VALID with O_DIV_READY low: ignored; the requester must hold the request.

## Test plan
- Reset, I_MODE=RUN at edge k, DEF_DIV=20 -> O_CLK rises after k+10, period 20, duty 50%; O_CE every 20 cycles; O_CYCLES=5 after 100 cycles.
- I_MODE=STEP, three I_STEP pulses 50 cycles apart -> exactly 3 O_CE, O_CYCLES=3; O_HALTED high 20 cycles after each step. A second I_STEP edge inside a step adds no pulse.
- RUN at div 20, offer I_DIV=6 mid high phase -> O_DIV_READY low until boundary; next periods are 6 cycles; no high or low phase shorter than 3 cycles.
- Offer I_DIV=0 and I_DIV=1 -> clamped to 2; O_CLK toggles every I_CLK cycle and O_CE pulses every 2 cycles.
- RUN, switch I_MODE to HALT 3 cycles into the high phase -> high phase completes its full 10 cycles, then O_CLK stays 0 and O_HALTED is 1. Set O_CYCLES near 2^32-1 and confirm wrap to 0.
- Assert RST mid high phase with a pending divisor -> O_CLK=0, O_CE=0, O_CYCLES=0 and O_DIV_READY=1 immediately; after release, period is 20.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/step/halt sequencer for the divided CPU clock.
// Builds a square O_CLK of programmable period from I_CLK and a one-cycle
// O_CE pulse on every O_CLK rising edge. Divisor changes are taken through
// a valid/ready handshake and only take effect on an O_CLK falling edge,
// so the divided clock never produces a short phase.
module cpu_clk_ctrl #(
  parameter logic [31:0] DEF_DIV = 32'd20,
  parameter logic [31:0] MIN_DIV = 32'd2
) (
  input  logic        I_CLK,
  input  logic        RST,
  input  logic [1:0]  I_MODE,
  input  logic        I_STEP,
  input  logic [31:0] I_DIV,
  input  logic        I_DIV_VALID,
  output logic        O_DIV_READY,
  output logic        O_CLK,
  output logic        O_CE,
  output logic        O_HALTED,
  output logic [31:0] O_CYCLES
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        clk_q, clk_d;
  logic        ce_q, ce_d;
  logic        halted_q, halted_d;
  logic [31:0] div_cur_q, div_cur_d;
  logic [31:0] div_pend_q, div_pend_d;
  logic        pend_q, pend_d;
  logic        ready_q, ready_d;
  logic        step_prev_q, step_prev_d;
  logic [31:0] cycles_q, cycles_d;

  logic [31:0] half;
  logic        toggle;
  logic        rise;
  logic        fall;
  logic        boundary;
  logic        step_edge;
  logic        accept;
  logic [31:0] div_clamped;

  // Period bookkeeping: half period, toggle point and the falling-edge boundary.
  always_comb begin
    half        = div_cur_q >> 1;
    toggle      = (state_q != ST_IDLE) && (cnt_q == half);
    rise        = toggle && !clk_q;
    fall        = toggle && clk_q;
    boundary    = (state_q == ST_IDLE) || fall;
    step_edge   = I_STEP && !step_prev_q;
    accept      = I_DIV_VALID && ready_q;
    div_clamped = (I_DIV < MIN_DIV) ? MIN_DIV : I_DIV;
  end

  // Sequencer, divided-clock generation and divisor handshake next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clk_d       = clk_q;
    div_cur_d   = div_cur_q;
    div_pend_d  = div_pend_q;
    pend_d      = pend_q;
    ready_d     = ready_q;
    step_prev_d = I_STEP;
    ce_d        = rise;
    cycles_d    = cycles_q + {31'd0, rise};

    case (state_q)
      ST_IDLE: begin
        cnt_d = 32'd0;
        clk_d = 1'b0;
        if (I_MODE == MODE_RUN) begin
          state_d = ST_RUN;
          cnt_d   = 32'd1;
        end else if ((I_MODE == MODE_STEP) && step_edge) begin
          state_d = ST_STEP;
          cnt_d   = 32'd1;
        end
      end
      ST_RUN, ST_STEP: begin
        if (toggle) begin
          clk_d = !clk_q;
          cnt_d = 32'd1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
        // A step always ends after one full period; run ends only when the
        // mode has left RUN, and only once the high phase has completed.
        if (fall && ((state_q == ST_STEP) || (I_MODE != MODE_RUN))) begin
          state_d = ST_IDLE;
          cnt_d   = 32'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 32'd0;
        clk_d   = 1'b0;
      end
    endcase

    // Pending divisor lands at a boundary so the new half period governs
    // the period starting there; ready reopens right after.
    if (boundary && pend_q) begin
      div_cur_d = div_pend_q;
      pend_d    = 1'b0;
      ready_d   = 1'b1;
    end

    // Ready is low whenever a divisor is pending, so accept and apply never
    // happen on the same edge.
    if (accept) begin
      div_pend_d = div_clamped;
      pend_d     = 1'b1;
      ready_d    = 1'b0;
    end

    halted_d = (state_d == ST_IDLE);
  end

  // State registers with asynchronous reset; reset drops O_CLK at once and
  // discards any in-flight divisor request.
  always_ff @(posedge I_CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 32'd0;
      clk_q       <= 1'b0;
      ce_q        <= 1'b0;
      halted_q    <= 1'b1;
      div_cur_q   <= DEF_DIV;
      div_pend_q  <= DEF_DIV;
      pend_q      <= 1'b0;
      ready_q     <= 1'b1;
      step_prev_q <= 1'b0;
      cycles_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_q       <= clk_d;
      ce_q        <= ce_d;
      halted_q    <= halted_d;
      div_cur_q   <= div_cur_d;
      div_pend_q  <= div_pend_d;
      pend_q      <= pend_d;
      ready_q     <= ready_d;
      step_prev_q <= step_prev_d;
      cycles_q    <= cycles_d;
    end
  end

  assign O_DIV_READY = ready_q;
  assign O_CLK       = clk_q;
  assign O_CE        = ce_q;
  assign O_HALTED    = halted_q;
  assign O_CYCLES    = cycles_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: directed bench for cpu_clk_ctrl.
// Inputs change and outputs are sampled on the falling edge of I_CLK.
module tb_cpu_clk_ctrl;

  logic        i_clk;
  logic        rst;
  logic [1:0]  i_mode;
  logic        i_step;
  logic [31:0] i_div;
  logic        i_div_valid;
  logic        o_div_ready;
  logic        o_clk;
  logic        o_ce;
  logic        o_halted;
  logic [31:0] o_cycles;

  int total;
  int bad;

  localparam logic [1:0] M_HALT = 2'b00;
  localparam logic [1:0] M_RUN  = 2'b01;
  localparam logic [1:0] M_STEP = 2'b10;

  cpu_clk_ctrl #(.DEF_DIV(32'd20), .MIN_DIV(32'd2)) dut (
    .I_CLK       (i_clk),
    .RST         (rst),
    .I_MODE      (i_mode),
    .I_STEP      (i_step),
    .I_DIV       (i_div),
    .I_DIV_VALID (i_div_valid),
    .O_DIV_READY (o_div_ready),
    .O_CLK       (o_clk),
    .O_CE        (o_ce),
    .O_HALTED    (o_halted),
    .O_CYCLES    (o_cycles)
  );

  // Free-running board clock, 10 time units per cycle.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic step,
                               input logic [31:0] div, input logic valid);
    i_mode      = mode;
    i_step      = step;
    i_div       = div;
    i_div_valid = valid;
  endtask

  // Advance n board-clock cycles; returns just after a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(M_HALT, 1'b0, 32'd20, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Called right after the edge that sets cnt to 1 with O_CLK low; checks
  // the square wave and CE for n cycles with half period h.
  task automatic checkRun(input string tag, input int h, input int n);
    for (int j = 1; j <= n; j++) begin
      tick(1);
      checkOutput({tag, "_clk"}, 32'(o_clk), 32'((j / h) % 2));
      checkOutput({tag, "_ce"}, 32'(o_ce), 32'((j % (2 * h)) == h));
    end
  endtask

  // Offer a divisor for one cycle (ready is high), then wait for ready to
  // come back; returns the number of cycles ready stayed low after acceptance.
  task automatic offerDiv(input string tag, input logic [31:0] d, output int waited);
    applyStimulus(i_mode, 1'b0, d, 1'b1);
    tick(1);
    i_div_valid = 1'b0;
    checkOutput({tag, "_rdy_low"}, 32'(o_div_ready), 32'd0);
    waited = 0;
    while (!o_div_ready && waited < 64) begin
      tick(1);
      waited++;
    end
    checkOutput({tag, "_rdy_back"}, 32'(o_div_ready), 32'd1);
  endtask

  // One step press followed by a dropped second press; spans 50 cycles.
  task automatic doStep(input string tag);
    int ce_cnt;
    ce_cnt = 0;
    applyStimulus(M_STEP, 1'b1, 32'd20, 1'b0);
    tick(1);
    checkOutput({tag, "_go"}, 32'(o_halted), 32'd0);
    i_step = 1'b0;
    for (int i = 1; i <= 49; i++) begin
      if (i == 5) i_step = 1'b1;
      if (i == 6) i_step = 1'b0;
      tick(1);
      if (o_ce) ce_cnt++;
      if (i == 19) checkOutput({tag, "_busy19"}, 32'(o_halted), 32'd0);
      if (i == 20) begin
        checkOutput({tag, "_halt20"}, 32'(o_halted), 32'd1);
        checkOutput({tag, "_clk20"}, 32'(o_clk), 32'd0);
      end
    end
    checkOutput({tag, "_ce_cnt"}, 32'(ce_cnt), 32'd1);
  endtask

  initial begin
    int w;
    int ce_cnt;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(M_HALT, 1'b0, 32'd20, 1'b0);
    tick(2);
    $display("[TB] reset values");
    checkOutput("rst_clk", 32'(o_clk), 32'd0);
    checkOutput("rst_ce", 32'(o_ce), 32'd0);
    checkOutput("rst_halted", 32'(o_halted), 32'd1);
    checkOutput("rst_cycles", o_cycles, 32'd0);
    checkOutput("rst_ready", 32'(o_div_ready), 32'd1);
    rst = 1'b0;
    tick(3);
    checkOutput("idle_clk", 32'(o_clk), 32'd0);

    $display("[TB] run at default divisor");
    applyStimulus(M_RUN, 1'b0, 32'd20, 1'b0);
    tick(1);
    checkOutput("run_halted", 32'(o_halted), 32'd0);
    checkRun("run20", 10, 100);
    checkOutput("run_cycles5", o_cycles, 32'd5);

    $display("[TB] divisor 6 offered mid high phase");
    tick(13);
    checkOutput("mid_high", 32'(o_clk), 32'd1);
    offerDiv("div6", 32'd6, w);
    checkOutput("div6_wait", 32'(w), 32'd6);
    checkRun("run6", 3, 12);

    $display("[TB] clamped divisors");
    offerDiv("div0", 32'd0, w);
    checkOutput("div0_wait", 32'(w), 32'd5);
    checkRun("run0", 1, 8);
    offerDiv("div1", 32'd1, w);
    checkOutput("div1_wait", 32'(w), 32'd1);
    checkRun("run1", 1, 8);
    offerDiv("div20", 32'd20, w);
    checkOutput("div20_wait", 32'(w), 32'd1);

    $display("[TB] halt requested inside high phase");
    checkRun("pre_halt", 10, 13);
    i_mode = M_HALT;
    for (int j = 14; j <= 20; j++) begin
      tick(1);
      checkOutput("halt_clk", 32'(o_clk), 32'(j < 20));
      if (j == 19) checkOutput("halt_busy19", 32'(o_halted), 32'd0);
      if (j == 20) checkOutput("halt_done20", 32'(o_halted), 32'd1);
    end
    ce_cnt = 0;
    for (int j = 0; j < 30; j++) begin
      tick(1);
      if (o_ce || o_clk) ce_cnt++;
    end
    checkOutput("halt_quiet", 32'(ce_cnt), 32'd0);
    checkOutput("halt_cycles", o_cycles, 32'd20);

    $display("[TB] mode 11 stays halted");
    i_mode = 2'b11;
    tick(25);
    checkOutput("mode11_halted", 32'(o_halted), 32'd1);
    checkOutput("mode11_cycles", o_cycles, 32'd20);

    $display("[TB] step mode");
    doReset();
    doStep("step1");
    doStep("step2");
    doStep("step3");
    checkOutput("step_cycles3", o_cycles, 32'd3);

    $display("[TB] cycle counter wrap");
    force dut.cycles_q = 32'hFFFF_FFFE;
    tick(1);
    release dut.cycles_q;
    tick(1);
    doStep("wrapA");
    checkOutput("wrap_max", o_cycles, 32'hFFFF_FFFF);
    doStep("wrapB");
    checkOutput("wrap_zero", o_cycles, 32'd0);

    $display("[TB] reset with pending divisor");
    doReset();
    applyStimulus(M_RUN, 1'b0, 32'd20, 1'b0);
    tick(1);
    checkRun("pre_rst", 10, 13);
    applyStimulus(M_RUN, 1'b0, 32'd6, 1'b1);
    tick(1);
    i_div_valid = 1'b0;
    checkOutput("prst_rdy_low", 32'(o_div_ready), 32'd0);
    tick(1);
    checkOutput("prst_cycles", o_cycles, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("arst_clk", 32'(o_clk), 32'd0);
    checkOutput("arst_ce", 32'(o_ce), 32'd0);
    checkOutput("arst_cycles", o_cycles, 32'd0);
    checkOutput("arst_ready", 32'(o_div_ready), 32'd1);
    checkOutput("arst_halted", 32'(o_halted), 32'd1);
    tick(1);
    rst = 1'b0;
    tick(1);
    checkRun("post_rst", 10, 40);
    checkOutput("post_rst_cycles", o_cycles, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
